pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary gate-drive stage placed directly downstream of `pwm`. It consumes the single-ended PWM waveform and produces a high-side / low-side output pair that is never asserted simultaneously. A programmable dead band, counted in clock cycles, is inserted at every switching edge and at enable. It is the last synchronous stage before the output pads.

## Interface
- `DT_WIDTH`, 8, width of the dead-time count; maximum dead band is 2^DT_WIDTH-1 cycles.
- `clk`  in  1  system clock, 50 MHz nominal, all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  stage enable; 0 forces both outputs low.
- `pwm_in`  in  1  PWM waveform from `pwm`.
- `dead_time`  in  DT_WIDTH  dead band length in clock cycles; 0 = no dead band.
- `pwm_h`  out  1  high-side drive, registered.
- `pwm_l`  out  1  low-side drive, registered.
- `in_dead`  out  1  high while a dead band is being counted, registered.

## Operation
- Clocking and reset: one clock `clk`. `rst_n` is asynchronous and active-low.
- FSM states: OFF, DEAD, HIGH, LOW. The stage also holds a `target` bit and a down-counter `cnt` of width DT_WIDTH.
- Outputs per state:
  - OFF: `pwm_h`=0, `pwm_l`=0, `in_dead`=0.
  - DEAD: `pwm_h`=0, `pwm_l`=0, `in_dead`=1.
  - HIGH: `pwm_h`=1, `pwm_l`=0, `in_dead`=0.
  - LOW: `pwm_h`=0, `pwm_l`=1, `in_dead`=0.
- Reset values: state OFF, `cnt`=0, `target`=0. All outputs are 0 while `rst_n`=0 and stay at reset values until the first edge after release.
- `en`=0 in any state:
  - Next state is OFF and `cnt` clears.
  - `en` has priority over all other transitions.
- Entering the dead band (`p` = sampled `pwm_in`):
  - OFF with `en`=1: `target` = `p`.
  - HIGH with `p`=0: `target` = 0.
  - LOW with `p`=1: `target` = 1.
  - If `dead_time`=0, go directly to HIGH (`target`=1) or LOW (`target`=0).
  - Otherwise go to DEAD and load `cnt` = `dead_time`.
- In DEAD:
  - If `p` != `target`: set `target` = `p`, reload `cnt` = `dead_time`, stay in DEAD (retrigger).
  - Else if `cnt`<=1: go to HIGH when `target`=1, LOW when `target`=0.
  - Else: decrement `cnt`.
- HIGH with `p`=1 and LOW with `p`=0 hold state.
- `dead_time` is sampled only on DEAD entry or retrigger. Changes during a count have no effect until the next entry.
- Safety invariant: `pwm_h` && `pwm_l` is never 1, in any cycle, including during reset assertion and the cycle after release.

## Timing
- `pwm_in` is sampled on each rising edge. An output change caused by that sample is visible after the same edge; input-to-output latency is 1 edge.
- Edge on `pwm_in` sampled at edge N, with `dead_time`=D>0:
  - Active output drops after edge N.
  - Both outputs stay low for exactly D cycles.
  - Opposite output rises after edge N+D.
- With D=0, the outputs swap after edge N; no cycle has both outputs high.
- Enable (`en` 0→1 sampled at edge N): the first asserted output rises after edge N+D.
- Disable (`en` 1→0 sampled at edge N): both outputs are 0 after edge N.
- Pulses on `pwm_in` shorter than D cycles keep retriggering DEAD. Both outputs remain low until `pwm_in` has been stable for D consecutive samples.
- Reset asserted mid-operation: outputs go to 0 asynchronously, without waiting for a clock edge.

## Configuration
- `PWM_DEADTIME_SYNC_EN` defined:
  - `pwm_in` passes through a 2-flop synchronizer (reset 0) before the FSM.
  - Input-to-output latency becomes 3 edges.
  - All other timing figures shift by 2 cycles.
- Undefined: `pwm_in` is used directly, as the upstream `pwm` is on the same `clk`.
- The bench runs both builds and offsets expected edges accordingly.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `pwm_in`=1, `en`=1 -> `pwm_h`=`pwm_l`=`in_dead`=0 throughout. After release with D=3, `pwm_h` rises 3 cycles after the first sampling edge.
- Steady switching: `dead_time`=3, `pwm_in` period 20 cycles at 50% -> each transition shows exactly 3 cycles with both low and `in_dead`=1. The overlap check (`pwm_h`&`pwm_l`) counts 0 errors.
- Zero dead time: `dead_time`=0, toggle `pwm_in` -> outputs swap after the sampling edge, `in_dead` never asserts, no overlap.
- Glitch/retrigger: `dead_time`=4, `pwm_in` 1→0, then 1 for 2 cycles, then 0 -> DEAD restarts on each change. `pwm_l` rises only 4 cycles after the final 0 is sampled.
- Disable mid-dead-band: `dead_time`=5, drop `en` in the 2nd dead cycle -> state OFF next edge. Re-enable with `pwm_in`=0 -> `pwm_l` rises 5 cycles later.
- Reset mid-HIGH: assert `rst_n`=0 between edges while `pwm_h`=1 -> `pwm_h` falls within `DELAY` (2 ns) of assertion, before the next clock edge.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate-drive stage with a programmable dead band.
// Build option: define PWM_DEADTIME_SYNC_EN to pass pwm_in through a 2-flop synchronizer.
//
//   state | meaning
//   ------+-----------------------------------------------
//   OFF   | disabled, both drives low
//   DEAD  | dead band counting, both drives low, in_dead=1
//   HIGH  | high-side drive on
//   LOW   | low-side drive on
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                in_dead
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                target_q, target_d;
  logic                pwm_h_q, pwm_h_d;
  logic                pwm_l_q, pwm_l_d;
  logic                in_dead_q, in_dead_d;
  logic                p;

`ifdef PWM_DEADTIME_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign p = sync2_q;
`else
  assign p = pwm_in;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;

    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF, S_HIGH, S_LOW: begin
          // Any of these leaves only when the drive has to change sides (or turn on).
          if ((state_q == S_OFF) || (state_q == S_HIGH && !p) || (state_q == S_LOW && p)) begin
            target_d = p;
            if (dead_time == '0) begin
              state_d = p ? S_HIGH : S_LOW;
            end else begin
              state_d = S_DEAD;
              cnt_d   = dead_time;
            end
          end
        end
        S_DEAD: begin
          if (p != target_q) begin
            target_d = p;
            cnt_d    = dead_time;
          end else if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = target_q ? S_HIGH : S_LOW;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they flop on the same edge.
    pwm_h_d   = (state_d == S_HIGH);
    pwm_l_d   = (state_d == S_LOW);
    in_dead_d = (state_d == S_DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      pwm_h_q   <= 1'b0;
      pwm_l_q   <= 1'b0;
      in_dead_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      pwm_h_q   <= pwm_h_d;
      pwm_l_q   <= pwm_l_d;
      in_dead_q <= in_dead_d;
    end
  end

  assign pwm_h   = pwm_h_q;
  assign pwm_l   = pwm_l_q;
  assign in_dead = in_dead_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime; expected output triples are queued per clock cycle.
module tb_pwm_deadtime;

`ifdef PWM_DEADTIME_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       pwm_in = 1'b1;
  logic [7:0] dead_time = 8'd3;
  logic       pwm_h, pwm_l, in_dead;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    cyc;
    logic  h;
    logic  l;
    logic  d;
    string tag;
  } exp_t;

  exp_t sb[$];

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pwm_in   (pwm_in),
    .dead_time(dead_time),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .in_dead  (in_dead)
  );

  always #10 clk = ~clk;

  // cyc = number of rising edges seen; outputs "after edge N" are checked when cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_seg(input int start, input int len, input logic h, input logic l,
                            input logic d, input string tag);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.cyc = start + i;
      e.h   = h;
      e.l   = l;
      e.d   = d;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Change pwm_in (sampled at the next edge) and queue the dead band plus the settled drive.
  task automatic pwm_edge(input logic v, input int d, input int hold, input string tag);
    int n;
    n         = cyc + 1;
    pwm_in    = v;
    dead_time = 8'(d);
    if (d > 0) begin
      expect_seg(n + S, d, 1'b0, 1'b0, 1'b1, tag);
      expect_seg(n + S + d, hold - d, v, !v, 1'b0, tag);
    end else begin
      expect_seg(n + S, hold, v, !v, 1'b0, tag);
    end
    tick(hold);
  endtask

  always @(negedge clk) begin
    checks++;
    if (pwm_h && pwm_l) begin
      errors++;
      $display("FAIL overlap cyc=%0d: pwm_h=%b pwm_l=%b, required not both 1", cyc, pwm_h, pwm_l);
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc ||
            {pwm_h, pwm_l, in_dead} !== {sb[i].h, sb[i].l, sb[i].d}) begin
          errors++;
          $display("FAIL %s cyc=%0d (exp cyc %0d): h/l/dead=%b%b%b, required %b%b%b",
                   sb[i].tag, cyc, sb[i].cyc, pwm_h, pwm_l, in_dead,
                   sb[i].h, sb[i].l, sb[i].d);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;

    // Reset held 3 cycles with pwm_in=1, en=1.
    expect_seg(1, 3, 1'b0, 1'b0, 1'b0, "reset_hold");
    tick(3);
    rst_n = 1'b1;
    pwm_edge(1'b1, 3, 10, "reset_release");

    // Steady switching, 20-cycle period, 50% duty, D=3.
    repeat (2) begin
      pwm_edge(1'b0, 3, 10, "sw_fall");
      pwm_edge(1'b1, 3, 10, "sw_rise");
    end

    // Zero dead time.
    pwm_edge(1'b0, 0, 6, "zd_fall");
    pwm_edge(1'b1, 0, 6, "zd_rise");
    pwm_edge(1'b0, 0, 6, "zd_fall2");

    // Glitch: 1 -> 0, 1 for 2 cycles, then 0; LOW only 4 cycles after final 0.
    pwm_edge(1'b1, 4, 8, "gl_pre");
    pwm_in = 1'b0;
    expect_seg(cyc + 1 + S, 3, 1'b0, 1'b0, 1'b1, "glitch");
    tick(1);
    pwm_in = 1'b1;
    tick(2);
    pwm_edge(1'b0, 4, 8, "glitch_end");

    // Disable in the 2nd dead cycle, then re-enable with pwm_in=0.
    n         = cyc + 1;
    pwm_in    = 1'b1;
    dead_time = 8'd5;
    expect_seg(n + S, 2, 1'b0, 1'b0, 1'b1, "dis_dead");
    tick(S + 2);
    en     = 1'b0;
    pwm_in = 1'b0;
    expect_seg(cyc + 1, 4, 1'b0, 1'b0, 1'b0, "dis_off");
    tick(4);
    en = 1'b1;
    expect_seg(cyc + 1, 5, 1'b0, 1'b0, 1'b1, "reen_dead");
    expect_seg(cyc + 6, 5, 1'b0, 1'b1, 1'b0, "reen_low");
    tick(10);

    // Asynchronous reset while HIGH.
    pwm_edge(1'b1, 2, 8, "pre_rst");
    tick(S + 1);
    checks++;
    if (pwm_h !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_high: pwm_h=%b, required 1", pwm_h);
    end
    #5;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pwm_h, pwm_l, in_dead} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: h/l/dead=%b%b%b 2ns after assertion, required 000",
               pwm_h, pwm_l, in_dead);
    end
    expect_seg(cyc, 2, 1'b0, 1'b0, 1'b0, "rst_low");
    tick(2);
    rst_n = 1'b1;
    tick(3);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
